muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit for the execute stage; the ALU's sequential companion for MIPS mult, multu, div and divu.
- Owns the architectural HI/LO registers and supports mthi/mtlo writes.
- Parametrised in width N and radix-2 only: one partial-product or quotient bit per cycle.
- The pipeline stalls on busy; it reads hi/lo directly for mfhi/mflo.

---
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit owning the HI/LO registers.
// One product or quotient bit per cycle; sign handling is done once on entry and once at completion.
module muldiv_unit #(
    parameter  int N  = 32,
    localparam int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         we_hi,
    input  logic         we_lo,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         dbz,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            is_div_q;
    logic            neg_q;      // sign of product / quotient
    logic            rem_neg_q;  // sign of remainder (dividend sign)
    logic            dz_q;
    logic [N-1:0]    mcand_q;    // multiplicand or divisor magnitude
    logic [2*N-1:0]  acc_q;      // product accumulator; low half doubles as quotient/dividend
    logic [N-1:0]    rem_q;
    logic [N-1:0]    hi_q;
    logic [N-1:0]    lo_q;
    logic            busy_q;
    logic            done_q;
    logic            dbz_q;

    // Operand preparation for an accepted start
    logic            a_neg;
    logic            b_neg;
    logic [N-1:0]    a_mag;
    logic [N-1:0]    b_mag;

    always_comb begin
        a_neg = ~op[0] & a[N-1];
        b_neg = ~op[0] & b[N-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One shift-add step and one restoring shift-subtract step
    logic [N:0]      mul_sum;
    logic [2*N-1:0]  acc_d;
    logic [N:0]      div_shift;
    logic [N:0]      div_diff;
    logic [N-1:0]    rem_d;
    logic [N-1:0]    quot_d;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
        acc_d     = {mul_sum, acc_q[N-1:1]};
        div_shift = {rem_q, acc_q[N-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        if (!div_diff[N]) begin
            rem_d  = div_diff[N-1:0];
            quot_d = {acc_q[N-2:0], 1'b1};
        end else begin
            rem_d  = div_shift[N-1:0];
            quot_d = {acc_q[N-2:0], 1'b0};
        end
    end

    // Sign fixup applied in FIN
    logic [2*N-1:0]  prod_fix;
    logic [N-1:0]    quot_fix;
    logic [N-1:0]    rem_fix;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quot_fix = neg_q ? -acc_q[N-1:0] : acc_q[N-1:0];
        rem_fix  = rem_neg_q ? -rem_q : rem_q;
    end

    // NOTE: every register here uses <= so all state updates see the pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: the synchronous reset also clears the datapath so an aborted operation leaves nothing behind.
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        dz_q      <= op[1] & (b == '0);
                        mcand_q   <= op[1] ? b_mag : a_mag;
                        acc_q     <= {{N{1'b0}}, (op[1] ? a_mag : b_mag)};
                        rem_q     <= '0;
                        cnt_q     <= CW'(N);
                        busy_q    <= 1'b1;
                        state_q   <= S_RUN;
                    end else begin
                        if (we_hi) hi_q <= wdata;
                        if (we_lo) lo_q <= wdata;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (is_div_q) begin
                        acc_q[N-1:0] <= quot_d;
                        rem_q        <= rem_d;
                    end else begin
                        acc_q <= acc_d;
                    end
                    if (cnt_q == CW'(1)) state_q <= S_FIN;
                end
                S_FIN: begin
                    if (!is_div_q) begin
                        hi_q <= prod_fix[2*N-1:N];
                        lo_q <= prod_fix[N-1:0];
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= dz_q ? {N{1'b1}} : quot_fix;
                    end
                    dbz_q   <= dz_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case sequences,
// and random operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          we_hi;
    logic          we_lo;
    logic [N-1:0]  wdata;
    logic          busy;
    logic          done;
    logic          dbz;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edbz;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: MIPS mult/multu/div/divu semantics from plain integer arithmetic
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] ehi, output logic [31:0] elo, output logic edbz);
        longint      sx, sy, sp;
        logic [63:0] up;
        edbz = 1'b0;
        case (o)
            2'd0: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                sp = sx * sy;
                {ehi, elo} = sp;
            end
            2'd1: begin
                up = {32'd0, x} * {32'd0, y};
                {ehi, elo} = up;
            end
            default: begin
                if (y == 32'd0) begin
                    elo  = 32'hFFFF_FFFF;
                    ehi  = x;
                    edbz = 1'b1;
                end else if (o == 2'd3) begin
                    elo = x / y;
                    ehi = x % y;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    elo = 32'h8000_0000;
                    ehi = 32'd0;
                end else begin
                    sx  = longint'($signed(x));
                    sy  = longint'($signed(y));
                    elo = 32'(sx / sy);
                    ehi = 32'(sx % sy);
                end
            end
        endcase
    endfunction

    // Called at a negedge; start is seen by the following rising edge
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the number of negedges from the one after the start edge until done, or -1
    task automatic wait_done(output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        int lat, bn;
        issue(o, x, y);
        wait_done(lat, bn);
        check({name, " latency"}, 64'(lat), 64'(N + 1));
        check({name, " busy_cycles"}, 64'(bn), 64'(N + 1));
        check({name, " busy_at_done"}, 64'(busy), 64'd0);
        check({name, " hi"}, 64'(hi), 64'(ehi));
        check({name, " lo"}, 64'(lo), 64'(elo));
        check({name, " dbz"}, 64'(dbz), 64'(edbz));
        @(negedge clk);
        check({name, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] ehi, elo, prev_lo;
        logic        edbz;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          lat, bn, dcnt;

        vecs[0] = '{"multu_max",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{"mult_neg",   2'd0, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2] = '{"div_neg",    2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{"divu_zero",  2'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{"multu_2x3",  2'd1, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
        vecs[5] = '{"div_ovf",    2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        vecs[6] = '{"div_zero_s", 2'd2, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{"div_negb",   2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};

        reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset dbz", 64'(dbz), 64'd0);

        // mthi then mtlo
        we_hi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b1; wdata = 32'hABCD;
        @(negedge clk);
        we_lo = 1'b0;
        check("mthi hi", 64'(hi), 64'h1234);
        check("mtlo lo", 64'(lo), 64'hABCD);
        check("mt busy", 64'(busy), 64'd0);

        // start with we_lo in the same cycle: write dropped, operation runs
        we_lo = 1'b1; wdata = 32'h5555;
        issue(2'd1, 32'd2, 32'd3);
        we_lo = 1'b0;
        check("start_we lo_kept", 64'(lo), 64'hABCD);
        check("start_we busy", 64'(busy), 64'd1);
        wait_done(lat, bn);
        check("start_we latency", 64'(lat), 64'(N + 1));
        check("start_we lo", 64'(lo), 64'd6);
        check("start_we hi", 64'(hi), 64'd0);
        @(negedge clk);

        // both strobes together
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
        check("mt_both hi", 64'(hi), 64'hCAFE_F00D);
        check("mt_both lo", 64'(lo), 64'hCAFE_F00D);

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].edbz);

        // start and mtlo while busy are both ignored
        prev_lo = lo;
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'd5; b = 32'd5; we_lo = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; we_lo = 1'b0;
        check("busy_we lo_kept", 64'(lo), 64'(prev_lo));
        wait_done(lat, bn);
        check("busy_ign seen_done", 64'(lat >= 0), 64'd1);
        check("busy_ign hi", 64'(hi), 64'd0);
        check("busy_ign lo", 64'(lo), 64'h8000_0000);
        check("busy_ign dbz", 64'(dbz), 64'd0);
        dcnt = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("busy_ign no_second_op", 64'(dcnt), 64'd0);

        // back-to-back: next start in the cycle done is high
        issue(2'd1, 32'd7, 32'd9);
        wait_done(lat, bn);
        check("b2b first lo", 64'(lo), 64'd63);
        issue(2'd0, 32'hFFFF_FFF9, 32'd3);
        wait_done(lat, bn);
        check("b2b latency", 64'(lat), 64'(N + 1));
        check("b2b hi", 64'(hi), 64'hFFFF_FFFF);
        check("b2b lo", 64'(lo), 64'hFFFF_FFEB);
        @(negedge clk);

        // reset in the middle of a divide
        issue(2'd3, 32'd50, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        dcnt = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort no_done", 64'(dcnt), 64'd0);
        run_op("divu_50_7", 2'd3, 32'd50, 32'd7, 32'd1, 32'd7, 1'b0);

        // randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'd1;
                3: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            model(ro, ra, rb, ehi, elo, edbz);
            run_op($sformatf("rand%0d op%0d %h/%h", i, ro, ra, rb), ro, ra, rb, ehi, elo, edbz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
